tdm_slot_sequencer: RTL
=======================

// Module: tdm_slot_sequencer
// PURPOSE
//   Sequences one audio frame as NUM_SLOTS TDM slots of SLOT_CYCLES clocks each.
//   Drives slot/cycle indices and strobes that time the per-slot datapath (sample
//   fetch, MAC, serializer). Next-count logic uses the team's 4-bit enabled
//   incrementer (inc4EnComb); this block adds the registers, terminal detection and FSM.
// PARAMETERS
//   NUM_SLOTS     16  slots per frame, legal 1..16
//   SLOT_CYCLES   4   clocks per slot, legal 1..16
//   AUTO_RESTART  0   1: DONE goes straight to RUN (free-running frames)
// PORTS
//   clk          in   1  system clock, all logic on posedge
//   rst          in   1  synchronous, active-high reset
//   start        in   1  request one frame; sampled in IDLE and DONE only
//   stall        in   1  freeze sequencing (back-pressure from datapath)
//   abort        in   1  cancel frame in progress
//   busy         out  1  high in RUN, PAUSE, DONE
//   slot_idx     out  4  current slot, 0..NUM_SLOTS-1
//   cyc_idx      out  4  cycle within slot, 0..SLOT_CYCLES-1
//   slot_stb     out  1  1-clk pulse on first cycle of every slot
//   frame_start  out  1  1-clk pulse on first cycle of slot 0
//   frame_done   out  1  1-clk pulse, frame completed normally
// BEHAVIOUR
//   - Reset value of every output: 0. State: IDLE. Counters: 0.
//   - All outputs registered; no combinational input-to-output path.
//   - States: IDLE, RUN, PAUSE, DONE.
//   - IDLE: start=1 at edge t -> RUN at t+1, slot_idx=0, cyc_idx=0, slot_stb=1, frame_start=1.
//   - RUN, stall=0: cyc_idx+1 each clk. At cyc_idx==SLOT_CYCLES-1: cyc_idx->0, slot_idx+1,
//     slot_stb=1. At slot_idx==NUM_SLOTS-1 and cyc_idx==SLOT_CYCLES-1: -> DONE.
//   - Frame length: exactly NUM_SLOTS*SLOT_CYCLES RUN cycles; frame_done at t+1+N*S.
//   - RUN, stall=1: -> PAUSE; counters hold; all strobes 0. Stall beats advance, including
//     on the terminal cycle.
//   - PAUSE: stall=0 -> RUN at the held position; slot_stb NOT re-issued.
//   - DONE (one clk): frame_done=1, counters 0. Next: RUN (new frame, frame_start=1)
//     if AUTO_RESTART=1 or start=1; else IDLE. stall ignored in DONE.
//   - start outside IDLE/DONE is ignored (no queuing).
//   - abort in RUN/PAUSE/DONE: next clk IDLE, counters 0, strobes 0, no frame_done.
//     Priority: rst > abort > stall > advance > start.
//   - Width rules: 4-bit counters; terminal compare uses the value before increment,
//     so NUM_SLOTS=16 / SLOT_CYCLES=16 wrap 15->0 via the dropped carry. No overflow path.
//   - SLOT_CYCLES=1: slot_stb high every RUN cycle; cyc_idx constant 0.
//   - rst mid-frame: all outputs 0 next clk, no frame_done.
// STRUCTURE
//   - Package tdm_seq_pkg: typedef enum logic [1:0] {IDLE,RUN,PAUSE,DONE} seq_state_t;
//     localparam SLOT_W=4, CYC_W=4.
//   - Sub-module: two inc4EnComb instances (cyc and slot next-count), inc inputs from FSM.
//   - Param legality checked with an elaboration-time assertion.
// TESTING
//   1. Defaults, start pulse at t -> frame_start at t+1, 16 slot_stb pulses 4 clks apart,
//      frame_done at t+65, then IDLE with busy=0.
//   2. stall high 3 clks at slot 5 cyc 2 -> indices hold, no strobes, resume at 5/3,
//      frame_done delayed by exactly 3 clks.
//   3. abort at slot 9 -> next clk IDLE, all outputs 0, no frame_done.
//   4. start held high -> DONE followed directly by RUN, frame_start one clk after frame_done.
//   5. NUM_SLOTS=16, SLOT_CYCLES=1 -> slot_idx 0..15, slot_stb every clk, frame_done at t+17.
//   6. rst during PAUSE and start during RUN -> rst clears all; start in RUN has no effect.

Source files
------------

// File: rtl/tdm_seq_pkg.sv
// Shared types and widths for the TDM slot sequencer.
package tdm_seq_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} seq_state_t;

   localparam int SLOT_W = 4;
   localparam int CYC_W  = 4;

endpackage

// File: rtl/tdm_slot_sequencer_inc4.sv
// 4-bit enabled incrementer; carry out of bit 3 is dropped so 15 wraps to 0.
module inc4EnComb (
   input  logic       i_en,
   input  logic [3:0] i_val,
   output logic [3:0] o_val
);

   assign o_val = i_en ? i_val + 4'd1 : i_val;

endmodule

// File: rtl/tdm_slot_sequencer.sv
// Frame sequencer: walks NUM_SLOTS slots of SLOT_CYCLES clocks each, with
// stall/abort control and registered strobes for the per-slot datapath.
//
//   state | meaning
//   IDLE  | waiting for start, counters parked at 0
//   RUN   | advancing cyc/slot counters every clock
//   PAUSE | stalled; position held, advance deferred until stall drops
//   DONE  | single clock, frame_done pulse, then RUN or IDLE
module tdm_slot_sequencer
   import tdm_seq_pkg::*;
#(
   parameter int NUM_SLOTS    = 16,
   parameter int SLOT_CYCLES  = 4,
   parameter int AUTO_RESTART = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stall,
   input  logic              abort,
   output logic              busy,
   output logic [SLOT_W-1:0] slot_idx,
   output logic [CYC_W-1:0]  cyc_idx,
   output logic              slot_stb,
   output logic              frame_start,
   output logic              frame_done
);

   if (NUM_SLOTS < 1 || NUM_SLOTS > 16 || SLOT_CYCLES < 1 || SLOT_CYCLES > 16 ||
       AUTO_RESTART < 0 || AUTO_RESTART > 1) begin : g_param_err
      $error("tdm_slot_sequencer: illegal NUM_SLOTS/SLOT_CYCLES/AUTO_RESTART");
   end

   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);
   localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(SLOT_CYCLES - 1);

   seq_state_t        r_state, w_state_nxt;
   logic [SLOT_W-1:0] r_slot_idx, w_slot_nxt, w_slot_inc;
   logic [CYC_W-1:0]  r_cyc_idx, w_cyc_nxt, w_cyc_inc;
   logic              r_busy, r_slot_stb, r_frame_start, r_frame_done;
   logic              w_slot_stb_nxt, w_frame_start_nxt, w_frame_done_nxt;
   logic              w_adv, w_cyc_last, w_slot_last;

   // Terminal compares use the pre-increment value, so a full 16 wraps cleanly.
   assign w_cyc_last  = (r_cyc_idx == CYC_LAST);
   assign w_slot_last = (r_slot_idx == SLOT_LAST);
   assign w_adv       = ((r_state == RUN) || (r_state == PAUSE)) && !abort && !stall;

   inc4EnComb u_cyc_inc (
      .i_en  (w_adv),
      .i_val (r_cyc_idx),
      .o_val (w_cyc_inc)
   );

   inc4EnComb u_slot_inc (
      .i_en  (w_adv && w_cyc_last),
      .i_val (r_slot_idx),
      .o_val (w_slot_inc)
   );

   always_comb begin
      w_state_nxt       = r_state;
      w_slot_nxt        = r_slot_idx;
      w_cyc_nxt         = r_cyc_idx;
      w_slot_stb_nxt    = 1'b0;
      w_frame_start_nxt = 1'b0;
      w_frame_done_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            w_slot_nxt = '0;
            w_cyc_nxt  = '0;
            if (!abort && start) begin
               w_state_nxt       = RUN;
               w_slot_stb_nxt    = 1'b1;
               w_frame_start_nxt = 1'b1;
            end
         end
         RUN, PAUSE: begin
            if (abort) begin
               w_state_nxt = IDLE;
               w_slot_nxt  = '0;
               w_cyc_nxt   = '0;
            end else if (stall) begin
               w_state_nxt = PAUSE;
            end else if (w_cyc_last && w_slot_last) begin
               w_state_nxt      = DONE;
               w_slot_nxt       = '0;
               w_cyc_nxt        = '0;
               w_frame_done_nxt = 1'b1;
            end else begin
               // A resume from PAUSE takes the deferred step, so no strobe repeats.
               w_state_nxt    = RUN;
               w_cyc_nxt      = w_cyc_last ? '0 : w_cyc_inc;
               w_slot_nxt     = w_slot_inc;
               w_slot_stb_nxt = w_cyc_last;
            end
         end
         DONE: begin
            w_slot_nxt = '0;
            w_cyc_nxt  = '0;
            if (abort) begin
               w_state_nxt = IDLE;
            end else if ((AUTO_RESTART != 0) || start) begin
               w_state_nxt       = RUN;
               w_slot_stb_nxt    = 1'b1;
               w_frame_start_nxt = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_slot_nxt  = '0;
            w_cyc_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_slot_idx    <= '0;
         r_cyc_idx     <= '0;
         r_busy        <= 1'b0;
         r_slot_stb    <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_done  <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_slot_idx    <= w_slot_nxt;
         r_cyc_idx     <= w_cyc_nxt;
         r_busy        <= (w_state_nxt != IDLE);
         r_slot_stb    <= w_slot_stb_nxt;
         r_frame_start <= w_frame_start_nxt;
         r_frame_done  <= w_frame_done_nxt;
      end
   end

   assign busy        = r_busy;
   assign slot_idx    = r_slot_idx;
   assign cyc_idx     = r_cyc_idx;
   assign slot_stb    = r_slot_stb;
   assign frame_start = r_frame_start;
   assign frame_done  = r_frame_done;

endmodule
